// File: rtl/serial_sum_collector.sv
// serial_sum_collector
//   Receive end of the serial adder datapath. Collects the LSB-first serial
//   sum stream (qualified by the controller's enable) into a parallel
//   WIDTH-bit word plus final carry. The completed word is presented on a
//   valid/ready handshake.
//
// Optional feature: define SERIAL_SUM_COLLECTOR_PARITY_EN to add parity_o,
//   the XOR of all WIDTH sum bits and the final carry, registered and held
//   together with result_o.
//
// Ports
//   clk            : clock, rising edge
//   reset_n        : synchronous active-low reset
//   frame_start_i  : one-cycle pulse from the controller load; opens a new frame
//   bit_valid_i    : sum_bit_i / carry_i valid this cycle
//   sum_bit_i      : serial sum bit, LSB first
//   carry_i        : adder carry, sampled with the WIDTH-th bit
//   result_o       : assembled sum, bit 0 = first bit received
//   carry_o        : final carry of the frame
//   result_valid_o : result_o / carry_o valid
//   result_ready_i : consumer accepts the result
//   busy_o         : collector is not idle
//   bit_count_o    : bits accepted in the current frame
//   overrun_o      : sticky, a frame was dropped while a result was pending
//   parity_o       : (optional) parity of the sum bits and final carry
module serial_sum_collector #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned CW    = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             frame_start_i,
  input  logic             bit_valid_i,
  input  logic             sum_bit_i,
  input  logic             carry_i,
  output logic [WIDTH-1:0] result_o,
  output logic             carry_o,
  output logic             result_valid_o,
  input  logic             result_ready_i,
  output logic             busy_o,
  output logic [CW-1:0]    bit_count_o,
  output logic             overrun_o
`ifdef SERIAL_SUM_COLLECTOR_PARITY_EN
  ,
  output logic             parity_o
`endif
);

  typedef enum logic [1:0] {
    IDLE,
    COLLECT,
    HOLD
  } state_t;

  state_t           state;
  logic [WIDTH-1:0] sreg;
  logic [WIDTH-1:0] shifted;
  logic             last_bit;

`ifdef SERIAL_SUM_COLLECTOR_PARITY_EN
  logic run_par;
`endif

  // New bits enter at the top so the first bit received ends up in bit 0.
  assign shifted  = {sum_bit_i, sreg[WIDTH-1:1]};
  assign last_bit = (bit_count_o == CW'(WIDTH - 1));
  assign busy_o   = (state != IDLE);

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state          <= IDLE;
      sreg           <= '0;
      bit_count_o    <= '0;
      result_o       <= '0;
      carry_o        <= 1'b0;
      result_valid_o <= 1'b0;
      overrun_o      <= 1'b0;
`ifdef SERIAL_SUM_COLLECTOR_PARITY_EN
      run_par        <= 1'b0;
      parity_o       <= 1'b0;
`endif
    end else begin
      unique case (state)
        IDLE: begin
          if (frame_start_i) begin
            state       <= COLLECT;
            bit_count_o <= '0;
            sreg        <= '0;
`ifdef SERIAL_SUM_COLLECTOR_PARITY_EN
            run_par     <= 1'b0;
`endif
          end
        end

        COLLECT: begin
          // A new frame_start aborts the partial frame; the bit arriving in
          // the same cycle belongs to nobody and is dropped.
          if (frame_start_i) begin
            bit_count_o <= '0;
            sreg        <= '0;
`ifdef SERIAL_SUM_COLLECTOR_PARITY_EN
            run_par     <= 1'b0;
`endif
          end else if (bit_valid_i) begin
            sreg <= shifted;
`ifdef SERIAL_SUM_COLLECTOR_PARITY_EN
            run_par <= run_par ^ sum_bit_i;
`endif
            if (last_bit) begin
              result_o       <= shifted;
              carry_o        <= carry_i;
              result_valid_o <= 1'b1;
              bit_count_o    <= '0;
              state          <= HOLD;
`ifdef SERIAL_SUM_COLLECTOR_PARITY_EN
              parity_o       <= run_par ^ sum_bit_i ^ carry_i;
`endif
            end else begin
              bit_count_o <= bit_count_o + CW'(1);
            end
          end
        end

        HOLD: begin
          if (result_ready_i) begin
            result_valid_o <= 1'b0;
            if (frame_start_i) begin
              state       <= COLLECT;
              bit_count_o <= '0;
              sreg        <= '0;
`ifdef SERIAL_SUM_COLLECTOR_PARITY_EN
              run_par     <= 1'b0;
`endif
            end else begin
              state <= IDLE;
            end
          end else if (frame_start_i) begin
            overrun_o <= 1'b1;
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/serial_sum_collector.md
Name: serial_sum_collector

Overview:
- Receive end of the serial adder datapath: takes the LSB-first serial sum stream produced while the adder controller drives enable, and reassembles it into a parallel WIDTH-bit result plus final carry.
- Sits downstream of the serial adder and its load/enable controller.
- Presents the completed word on a valid/ready handshake to the consumer.

Parameters:
- WIDTH, 8, number of sum bits per frame; must be at least 2.
- CW, $clog2(WIDTH+1), bit-counter width; derived, not overridden.

Ports:
- clk  input  1  clock, rising-edge.
- reset_n  input  1  synchronous active-low reset.
- frame_start_i  input  1  one-cycle pulse from controller load; opens a new frame.
- bit_valid_i  input  1  controller enable; sum_bit_i/carry_i are valid this cycle.
- sum_bit_i  input  1  serial sum bit, LSB first.
- carry_i  input  1  adder carry; sampled with the WIDTH-th bit.
- result_o  output  WIDTH  assembled sum, bit 0 = first bit received.
- carry_o  output  1  final carry of the frame.
- result_valid_o  output  1  result_o/carry_o valid.
- result_ready_i  input  1  consumer accepts result.
- busy_o  output  1  high when state is not IDLE.
- bit_count_o  output  CW  bits accepted in the current frame.
- overrun_o  output  1  sticky error flag: a frame was dropped.

Behaviour:
- Reset: synchronous, active-low, sampled on clk rising edge.
  - Values: state=IDLE, result_o=0, carry_o=0, result_valid_o=0, bit_count_o=0, overrun_o=0, shift register=0.
  - Reset asserted in any state, including mid-frame, discards the partial frame with no result.
- States: IDLE, COLLECT, HOLD. busy_o = (state != IDLE).
- IDLE:
  - frame_start_i=1 -> COLLECT; bit_count cleared to 0; shift register cleared.
  - bit_valid_i is ignored in IDLE.
- COLLECT:
  - Each edge with bit_valid_i=1: shift register <= {sum_bit_i, sreg[WIDTH-1:1]}; bit_count+1.
  - Idle cycles (bit_valid_i=0) hold all state; gaps between bits are legal.
  - On the edge accepting the WIDTH-th bit:
    - result_o <= {sum_bit_i, sreg[WIDTH-1:1]}; carry_o <= carry_i; result_valid_o <= 1.
    - bit_count returns to 0; next state HOLD.
    - result_valid_o is therefore visible in the cycle after the last bit.
  - frame_start_i=1 (with or without bit_valid_i) aborts the frame. bit_count <= 0, sreg cleared, stay COLLECT; that cycle's bit is discarded. No result and no overrun.
- HOLD:
  - result_valid_o=1; result_o/carry_o stable until the handshake.
  - result_ready_i=1 -> result_valid_o <= 0. Next state is COLLECT if frame_start_i=1 in the same cycle, else IDLE.
  - frame_start_i=1 with result_ready_i=0: overrun_o <= 1 (sticky until reset), new frame dropped, remain HOLD.
  - bit_valid_i is ignored in HOLD.
- result_o/carry_o keep their last value after the handshake until the next frame completes.
- No combinational path from any input to any output; all outputs are registered.

Optional Feature:
- Macro: SERIAL_SUM_COLLECTOR_PARITY_EN.
- Defined:
  - Adds output parity_o, 1 bit, reset value 0.
  - A running XOR is cleared at frame start and updated per accepted bit.
  - parity_o = XOR of all WIDTH sum bits and carry; registered on the same edge as result_o, held identically.
- Undefined: port and logic absent; all other behaviour unchanged.

Test Plan:
- Reset: reset_n=0 for 2 cycles from any state -> all outputs 0, busy_o=0, bit_count_o=0.
- Basic frame: frame_start, then 8 consecutive bits of 8'hA5 LSB first, carry_i=1 on the 8th bit, ready=1 -> cycle after 8th bit: result_o=8'hA5, carry_o=1, result_valid_o=1 for exactly 1 cycle, then IDLE. With parity macro: parity_o=1.
- Gapped bits: same frame with bit_valid_i low for 2 cycles between each bit -> bit_count_o steps 1..7 then 0; result_o=8'hA5; valid one cycle after the last bit.
- Backpressure: frame 8'h0F, ready=0 for 5 cycles -> result_valid_o held, result_o=8'h0F stable. frame_start during HOLD -> overrun_o=1, frame dropped. Ready=1 -> IDLE; overrun_o stays 1.
- Abort: frame_start, 3 bits, then frame_start again, then 8 bits of 8'h3C, carry 0 -> bit_count_o returns 0 at the abort; result_o=8'h3C, carry_o=0, overrun_o=0.
- Reset mid-frame: reset_n=0 after 4 accepted bits -> IDLE, bit_count_o=0, result_valid_o never asserts. A following frame of 8'hFF, carry 1 -> result_o=8'hFF, carry_o=1.
